// File: rtl/fifo_sample_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_sample_reader_if
//
// Bundles the two data paths of the sample reader: the FIFO read port on
// one side and the valid/ready sample stream toward the DAC/serializer on
// the other. Signal suffixes are written from the reader's point of view.
//
// Signals:
//   empty_i  - FIFO empty flag
//   rd_en_o  - FIFO pop strobe
//   data_i   - FIFO read data, valid the cycle after rd_en_o
//   data_o   - registered sample toward downstream
//   valid_o  - data_o valid
//   ready_i  - downstream accepts data_o
//
// Modports:
//   master - the reader itself
//   slave  - the FIFO + downstream environment
// ---------------------------------------------------------------------------
interface fifo_sample_reader_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic                         empty_i;
  logic                         rd_en_o;
  logic signed [DATA_WIDTH-1:0] data_i;
  logic signed [DATA_WIDTH-1:0] data_o;
  logic                         valid_o;
  logic                         ready_i;

  modport master (
    input  empty_i,
    input  data_i,
    input  ready_i,
    output rd_en_o,
    output data_o,
    output valid_o
  );

  modport slave (
    output empty_i,
    output data_i,
    output ready_i,
    input  rd_en_o,
    input  data_o,
    input  valid_o
  );

endinterface

// File: rtl/fifo_sample_reader.sv
// ---------------------------------------------------------------------------
// fifo_sample_reader
//
// Read-side consumer of the function-generator sample FIFO. Pops one signed
// sample per programmable sample period, holds it on a valid/ready port
// until downstream takes it, counts consumed samples and raises a sticky
// underrun flag when a sample falls due while the FIFO is empty.
//
// Ports:
//   clk            - system clock, rising edge
//   rst            - asynchronous, active-high reset
//   en_i           - run enable
//   div_i          - idle cycles inserted after each accepted handshake
//   clr_underrun_i - clears underrun_o (a simultaneous set wins)
//   underrun_o     - sticky underrun flag
//   count_o        - number of samples popped, wraps
//   bus            - FIFO read port + output stream (master modport)
//
// With ready held high one sample takes 3 + div_i cycles:
// FETCH, LOAD, OUT, then div_i cycles of PACE.
// ---------------------------------------------------------------------------
module fifo_sample_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic                  clr_underrun_i,
  output logic                  underrun_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  fifo_sample_reader_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    OUT,
    PACE
  } state_e;

  localparam logic [DIV_WIDTH-1:0] PACE_ONE = DIV_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_e                       state_q, state_d;
  logic [DIV_WIDTH-1:0]         pace_q, pace_d;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;
  logic                         valid_q, valid_d;
  logic [CNT_WIDTH-1:0]         count_q, count_d;
  logic                         underrun_q, underrun_d;
  logic                         fetchFromRun_q, fetchFromRun_d;
  logic                         rdEn;
  logic                         handshake;
  logic                         underrunSet;

  assign handshake = valid_q && bus.ready_i;

  // State register and all datapath registers. Everything returns to a
  // quiet IDLE on reset; rd_en_o follows because it is decoded from state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pace_q         <= '0;
      data_q         <= '0;
      valid_q        <= 1'b0;
      count_q        <= '0;
      underrun_q     <= 1'b0;
      fetchFromRun_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pace_q         <= pace_d;
      data_q         <= data_d;
      valid_q        <= valid_d;
      count_q        <= count_d;
      underrun_q     <= underrun_d;
      fetchFromRun_q <= fetchFromRun_d;
    end
  end

  // Next-state and datapath logic. LOAD and OUT deliberately ignore en_i so
  // a sample that has already left the FIFO is always delivered; only FETCH
  // and PACE react to en_i dropping.
  always_comb begin
    state_d = state_q;
    pace_d  = pace_q;
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    rdEn    = 1'b0;

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (en_i) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        // Only pop when enabled and data exists, so at most one read is
        // ever outstanding and an empty FIFO is never popped.
        rdEn = en_i && !bus.empty_i;
        if (!en_i) begin
          state_d = IDLE;
        end else if (!bus.empty_i) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        data_d  = bus.data_i;
        valid_d = 1'b1;
        count_d = count_q + CNT_ONE;
        state_d = OUT;
      end

      OUT: begin
        if (handshake) begin
          valid_d = 1'b0;
          if (div_i == '0) begin
            state_d = FETCH;
          end else begin
            // div_i is captured here only, so later changes affect the
            // next period and never the one in progress.
            pace_d  = div_i;
            state_d = PACE;
          end
        end
      end

      PACE: begin
        if (!en_i) begin
          pace_d  = '0;
          state_d = IDLE;
        end else begin
          pace_d = pace_q - PACE_ONE;
          // Leaving at one (rather than zero) makes the dwell exactly
          // div_i cycles; the <= also keeps a stray zero from stalling.
          if (pace_q <= PACE_ONE) begin
            state_d = FETCH;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Remember whether FETCH was entered from a running period (OUT or PACE)
  // so underrun is judged only on that first cycle, never after a start
  // from IDLE and never on later cycles spent waiting for data.
  always_comb begin
    fetchFromRun_d = (state_d == FETCH) &&
                     ((state_q == OUT) || (state_q == PACE));
  end

  // Sticky underrun flag; a set in the same cycle as a clear takes priority
  // so a fresh underrun is never swallowed by software acknowledging an
  // older one.
  always_comb begin
    underrunSet = (state_q == FETCH) && fetchFromRun_q &&
                  bus.empty_i && en_i;
    underrun_d  = underrun_q;
    if (underrunSet) begin
      underrun_d = 1'b1;
    end else if (clr_underrun_i) begin
      underrun_d = 1'b0;
    end
  end

  assign bus.rd_en_o = rdEn;
  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign underrun_o  = underrun_q;
  assign count_o     = count_q;

  // A pop must never be issued against an empty FIFO.
  assert property (@(posedge clk) disable iff (rst)
    bus.rd_en_o |-> !bus.empty_i);

  // A presented sample stays valid and unchanged until it is taken.
  assert property (@(posedge clk) disable iff (rst)
    (valid_q && !bus.ready_i) |=> (valid_q && (data_q == $past(data_q))));

endmodule

// File: tb/tb_fifo_sample_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_sample_reader
//
// Directed bench for fifo_sample_reader. A small ring-buffer FIFO model
// feeds the reader (data_i valid the cycle after rd_en_o) and a monitor
// records every accepted sample, the count at acceptance and the cycle of
// each valid_o rising edge. The counter is built 8 bits wide so the wrap
// boundary is reached in a few hundred samples.
// ---------------------------------------------------------------------------
module tb_fifo_sample_reader;

  localparam int DATA_WIDTH = 16;
  localparam int DIV_WIDTH  = 8;
  localparam int CNT_WIDTH  = 8;
  localparam int FIFO_DEPTH = 512;
  localparam int WRAP_N     = 260;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic [DIV_WIDTH-1:0] div;
  logic                 clrUnderrun;
  logic                 underrun;
  logic [CNT_WIDTH-1:0] count;

  fifo_sample_reader_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_sample_reader #(
    .DATA_WIDTH(DATA_WIDTH),
    .DIV_WIDTH (DIV_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en),
    .div_i         (div),
    .clr_underrun_i(clrUnderrun),
    .underrun_o    (underrun),
    .count_o       (count),
    .bus           (bus)
  );

  int passCount = 0;
  int checkCount = 0;

  // Clock: 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: tasks push at wrPtr, the read process pops at rdPtr.
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  int wrPtr = 0;
  int rdPtr = 0;

  assign bus.empty_i = (wrPtr == rdPtr);

  always @(posedge clk) begin
    if (bus.rd_en_o) begin
      bus.data_i <= mem[rdPtr % FIFO_DEPTH];
      rdPtr      <= rdPtr + 1;
    end
  end

  // Monitor, sampled mid-cycle away from the active edge.
  logic [DATA_WIDTH-1:0] acceptedData[$];
  logic [CNT_WIDTH-1:0]  acceptedCount[$];
  int                    riseCycles[$];
  logic                  prevValid = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prevValid = 1'b0;
    end else begin
      if (bus.valid_o && bus.ready_i) begin
        acceptedData.push_back(bus.data_o);
        acceptedCount.push_back(count);
      end
      if (bus.valid_o && !prevValid) begin
        riseCycles.push_back(cyc);
      end
      prevValid = bus.valid_o;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_WIDTH-1:0] v);
    mem[wrPtr % FIFO_DEPTH] = v;
    wrPtr = wrPtr + 1;
  endtask

  task automatic waitValid(input int maxCycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      tick;
      if (bus.valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic doReset;
    rst         = 1'b1;
    en          = 1'b0;
    div         = '0;
    clrUnderrun = 1'b0;
    bus.ready_i = 1'b0;
    tick;
    tick;
    rst   = 1'b0;
    wrPtr = rdPtr;
    acceptedData.delete();
    acceptedCount.delete();
    riseCycles.delete();
  endtask

  // Reset values, then an asynchronous reset while a sample is presented.
  task automatic test_reset;
    bit ok;
    doReset;
    checkCount++;
    if ({bus.valid_o, bus.data_o} !== 17'h0)
      $display("[TB] FAIL reset_valid_data: got %h, expected 0", {bus.valid_o, bus.data_o});
    else passCount++;
    checkCount++;
    if ({underrun, count, bus.rd_en_o} !== 10'h0)
      $display("[TB] FAIL reset_status: got %h, expected 0", {underrun, count, bus.rd_en_o});
    else passCount++;

    push(16'h1234);
    push(16'h5555);
    bus.ready_i = 1'b0;
    en = 1'b1;
    waitValid(10, ok);
    checkCount++;
    if (!ok) $display("[TB] FAIL reset_reach_out: valid_o not seen within 10 cycles");
    else passCount++;
    checkCount++;
    if ({bus.valid_o, bus.data_o, count} !== {1'b1, 16'h1234, 8'd1})
      $display("[TB] FAIL pre_reset_out: got %h, expected %h", {bus.valid_o, bus.data_o, count}, {1'b1, 16'h1234, 8'd1});
    else passCount++;

    #2;
    rst = 1'b1;
    #1;
    checkCount++;
    if ({bus.valid_o, bus.data_o, count, underrun, bus.rd_en_o} !== 27'h0)
      $display("[TB] FAIL async_reset: got %h, expected 0", {bus.valid_o, bus.data_o, count, underrun, bus.rd_en_o});
    else passCount++;

    tick;
    rst = 1'b0;
    #1;
    checkCount++;
    if (bus.rd_en_o !== 1'b0)
      $display("[TB] FAIL post_reset_idle: rd_en_o got %b, expected 0", bus.rd_en_o);
    else passCount++;
    tick;
    checkCount++;
    if (bus.rd_en_o !== 1'b1)
      $display("[TB] FAIL post_reset_fetch: rd_en_o got %b, expected 1", bus.rd_en_o);
    else passCount++;
  endtask

  // Three samples at div_i=2 with ready held high: period 5 cycles.
  task automatic test_sequence;
    logic [DATA_WIDTH-1:0] expVals [3];
    expVals[0] = 16'h0001;
    expVals[1] = 16'h7FFF;
    expVals[2] = 16'h8000;
    doReset;
    for (int i = 0; i < 3; i++) push(expVals[i]);
    div = 8'd2;
    bus.ready_i = 1'b1;
    en = 1'b1;
    repeat (30) tick;

    checkCount++;
    if (acceptedData.size() !== 3)
      $display("[TB] FAIL seq_accept_count: got %0d, expected 3", acceptedData.size());
    else passCount++;
    if (acceptedData.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        checkCount++;
        if (acceptedData[i] !== expVals[i])
          $display("[TB] FAIL seq_data%0d: got %h, expected %h", i, acceptedData[i], expVals[i]);
        else passCount++;
      end
    end
    checkCount++;
    if (riseCycles.size() !== 3)
      $display("[TB] FAIL seq_rise_count: got %0d, expected 3", riseCycles.size());
    else passCount++;
    if (riseCycles.size() >= 3) begin
      for (int i = 1; i < 3; i++) begin
        checkCount++;
        if (riseCycles[i] - riseCycles[i-1] !== 5)
          $display("[TB] FAIL seq_period%0d: got %0d, expected 5", i, riseCycles[i] - riseCycles[i-1]);
        else passCount++;
      end
    end
    checkCount++;
    if (count !== 8'd3)
      $display("[TB] FAIL seq_count: got %0d, expected 3", count);
    else passCount++;
    checkCount++;
    if ({underrun, bus.valid_o, bus.rd_en_o} !== 3'b100)
      $display("[TB] FAIL seq_underrun_wait: got %b, expected 100", {underrun, bus.valid_o, bus.rd_en_o});
    else passCount++;
  endtask

  // Back-pressure for 10 cycles with en_i dropped while the sample is held.
  task automatic test_backpressure;
    bit ok;
    int good;
    doReset;
    push(16'h0BEE);
    div = 8'd0;
    bus.ready_i = 1'b0;
    en = 1'b1;
    waitValid(10, ok);
    checkCount++;
    if (!ok) $display("[TB] FAIL bp_reach_out: valid_o not seen within 10 cycles");
    else passCount++;

    good = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) en = 1'b0;
      tick;
      if (bus.valid_o === 1'b1 && bus.data_o === 16'h0BEE) good++;
    end
    checkCount++;
    if (good !== 10)
      $display("[TB] FAIL bp_hold: held cycles got %0d, expected 10", good);
    else passCount++;

    bus.ready_i = 1'b1;
    tick;
    bus.ready_i = 1'b0;
    checkCount++;
    if (bus.valid_o !== 1'b0 || acceptedData.size() !== 1)
      $display("[TB] FAIL bp_handshake: valid %b accepted %0d, expected 0 and 1", bus.valid_o, acceptedData.size());
    else passCount++;

    push(16'h0CCC);
    good = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (bus.rd_en_o === 1'b0 && bus.valid_o === 1'b0) good++;
    end
    checkCount++;
    if (good !== 4 || count !== 8'd1 || underrun !== 1'b0)
      $display("[TB] FAIL bp_idle: quiet %0d count %0d underrun %b, expected 4 1 0", good, count, underrun);
    else passCount++;
  endtask

  // Start from IDLE against an empty FIFO, then deliver one sample.
  task automatic test_empty_start;
    int good;
    doReset;
    div = 8'd0;
    bus.ready_i = 1'b1;
    en = 1'b1;
    good = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (bus.rd_en_o === 1'b0 && underrun === 1'b0) good++;
    end
    checkCount++;
    if (good !== 20)
      $display("[TB] FAIL empty_wait: quiet cycles got %0d, expected 20", good);
    else passCount++;

    push(16'h00AA);
    #1;
    checkCount++;
    if (bus.rd_en_o !== 1'b1)
      $display("[TB] FAIL empty_pop: rd_en_o got %b, expected 1", bus.rd_en_o);
    else passCount++;
    tick;
    checkCount++;
    if (bus.valid_o !== 1'b0)
      $display("[TB] FAIL empty_load: valid_o got %b, expected 0", bus.valid_o);
    else passCount++;
    // Third cycle counting the one in which empty_i dropped.
    tick;
    checkCount++;
    if ({bus.valid_o, bus.data_o} !== {1'b1, 16'h00AA})
      $display("[TB] FAIL empty_valid: got %h, expected %h", {bus.valid_o, bus.data_o}, {1'b1, 16'h00AA});
    else passCount++;
  endtask

  // Underrun set and clear in the same cycle, then clear alone.
  task automatic test_underrun_clear;
    bit ok;
    doReset;
    push(16'h0011);
    div = 8'd0;
    bus.ready_i = 1'b1;
    en = 1'b1;
    waitValid(10, ok);
    checkCount++;
    if (!ok) $display("[TB] FAIL ur_reach_out: valid_o not seen within 10 cycles");
    else passCount++;

    tick;
    checkCount++;
    if (underrun !== 1'b0)
      $display("[TB] FAIL ur_first_fetch: underrun got %b, expected 0", underrun);
    else passCount++;
    clrUnderrun = 1'b1;
    tick;
    checkCount++;
    if (underrun !== 1'b1)
      $display("[TB] FAIL ur_set_wins: underrun got %b, expected 1", underrun);
    else passCount++;
    tick;
    checkCount++;
    if (underrun !== 1'b0)
      $display("[TB] FAIL ur_clear: underrun got %b, expected 0", underrun);
    else passCount++;
    clrUnderrun = 1'b0;
    repeat (3) tick;
    checkCount++;
    if (underrun !== 1'b0)
      $display("[TB] FAIL ur_no_reset_in_fetch: underrun got %b, expected 0", underrun);
    else passCount++;
  endtask

  // Stream past the counter wrap at div_i=0 and scoreboard every sample.
  task automatic test_wrap;
    int dataErr;
    int cntErr;
    doReset;
    for (int i = 0; i < WRAP_N; i++) push(16'(i * 257 + 3));
    div = 8'd0;
    bus.ready_i = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick;
      if (acceptedData.size() >= WRAP_N) break;
    end
    repeat (6) tick;

    checkCount++;
    if (acceptedData.size() !== WRAP_N)
      $display("[TB] FAIL wrap_accept_count: got %0d, expected %0d", acceptedData.size(), WRAP_N);
    else passCount++;

    dataErr = 0;
    cntErr = 0;
    for (int i = 0; i < acceptedData.size() && i < WRAP_N; i++) begin
      if (acceptedData[i] !== 16'(i * 257 + 3)) dataErr++;
      if (acceptedCount[i] !== 8'((i + 1) % 256)) cntErr++;
    end
    checkCount++;
    if (dataErr !== 0)
      $display("[TB] FAIL wrap_data: mismatched samples got %0d, expected 0", dataErr);
    else passCount++;
    checkCount++;
    if (cntErr !== 0)
      $display("[TB] FAIL wrap_count_seq: mismatched counts got %0d, expected 0", cntErr);
    else passCount++;
    if (acceptedCount.size() >= 256) begin
      checkCount++;
      if (acceptedCount[255] !== 8'd0)
        $display("[TB] FAIL wrap_to_zero: got %0d, expected 0", acceptedCount[255]);
      else passCount++;
    end
    checkCount++;
    if (count !== 8'd4)
      $display("[TB] FAIL wrap_final_count: got %0d, expected 4", count);
    else passCount++;
  endtask

  initial begin
    rst         = 1'b1;
    en          = 1'b0;
    div         = '0;
    clrUnderrun = 1'b0;
    bus.ready_i = 1'b0;
    $display("[TB] starting fifo_sample_reader tests");
    test_reset;
    test_sequence;
    test_backpressure;
    test_empty_start;
    test_underrun_clear;
    test_wrap;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fifo_sample_reader.md
Name: fifo_sample_reader

Overview:
- Read-side consumer for the sample FIFO fed by the function generator.
- Pops one signed sample per programmable sample period, presents it on a valid/ready output port, counts consumed samples and flags underrun.
- Sits between the FIFO read port and the downstream DAC/serializer interface.

Parameters:
- DATA_WIDTH, 16, sample width; matches FIFO data width.
- DIV_WIDTH, 8, width of the sample-period divider.
- CNT_WIDTH, 16, width of the consumed-sample counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en_i  input  1  run enable.
- div_i  input  DIV_WIDTH  idle cycles inserted between samples after each accepted handshake.
- empty_i  input  1  FIFO empty flag.
- rd_en_o  output  1  FIFO pop strobe.
- data_i  input  DATA_WIDTH (signed)  FIFO read data; valid the cycle after rd_en_o.
- data_o  output  DATA_WIDTH (signed)  registered sample.
- valid_o  output  1  data_o valid.
- ready_i  input  1  downstream accepts data_o.
- underrun_o  output  1  sticky flag: a sample was due while the FIFO was empty.
- clr_underrun_i  input  1  clears underrun_o.
- count_o  output  CNT_WIDTH  number of samples popped; wraps.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, data_o=0, valid_o=0, underrun_o=0, count_o=0, pace counter=0. rd_en_o=0 because it is decoded from state.
- Interface: one clock, clk. Reset is asynchronous and active-high on rst.
- FSM states: IDLE, FETCH, LOAD, OUT, PACE.
- IDLE: valid_o=0. en_i=1 -> FETCH. No underrun detection in IDLE.
- FETCH:
  - rd_en_o = en_i && !empty_i (combinational from state, en_i and empty_i).
  - en_i=0 -> IDLE.
  - !empty_i -> LOAD.
  - empty_i -> stay in FETCH.
- LOAD:
  - data_o <= data_i.
  - valid_o <= 1.
  - count_o <= count_o+1, wrapping from all-ones to 0.
  - -> OUT unconditionally; en_i is ignored, so a popped sample is never lost.
- OUT:
  - valid_o=1, and data_o is held stable until ready_i=1.
  - On valid_o&&ready_i: valid_o <= 0.
    - If div_i==0 -> FETCH.
    - Else the pace counter loads div_i -> PACE.
  - en_i falling in OUT does not drop the sample; the handshake completes first.
- PACE:
  - Counter decrements each cycle.
  - At counter==1 -> FETCH. Exactly div_i cycles are spent in PACE.
  - en_i=0 -> IDLE immediately.
  - div_i changes take effect at the next load only.
- Underrun:
  - underrun_o sets when FETCH is entered from PACE or OUT with empty_i=1 and en_i=1, on that first FETCH cycle only.
  - Entry from IDLE never sets it.
  - Sticky until clr_underrun_i=1.
  - Set and clear in the same cycle: set wins.
- Latency: en_i sampled high in IDLE with FIFO non-empty.
  - Cycle +1: FETCH, rd_en_o=1.
  - Cycle +2: LOAD.
  - Cycle +3: valid_o=1.
- Sample period with ready_i tied high: 3 + div_i cycles (FETCH, LOAD, OUT, div_i×PACE).
- Never more than one pop outstanding. rd_en_o is never asserted while empty_i=1 or outside FETCH.
- valid_o deasserts only after a handshake or reset; there is no abort path.

Test Plan:
- Reset mid-OUT (valid_o=1, data_o=0x1234), assert rst asynchronously -> all outputs 0 immediately; state IDLE after release.
- FIFO holds 0x0001, 0x7FFF, 0x8000; en_i=1, div_i=2, ready_i=1 -> data_o sequence 0x0001, 0x7FFF, 0x8000; valid_o rising edges spaced 5 cycles apart; count_o=3; then FETCH waits with underrun_o=1.
- FIFO holds one sample, ready_i=0 for 10 cycles, en_i dropped during OUT -> data_o stable, valid_o held for all 10 cycles; on ready_i=1, handshake completes, then FSM returns to IDLE; count_o=1.
- en_i=1 with FIFO empty from IDLE for 20 cycles -> rd_en_o=0 and underrun_o=0 throughout; push 0x00AA -> valid_o=1 three cycles after empty_i falls.
- Underrun set and clr_underrun_i=1 in the same cycle -> underrun_o=1; clr_underrun_i alone next cycle -> underrun_o=0.
- Preload count_o near wrap by streaming 65536 samples at div_i=0 -> count_o wraps to 0; no pops are lost or duplicated (check by scoreboard).
